// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply sequencer.
// Provides the FSM state type, matrix/stream geometry, counter widths
// and the slot-to-bit-offset helper used for flat 9*W packing.
package matmul_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    localparam int unsigned MAT_N         = 3;
    localparam int unsigned MAT_ELEMS     = MAT_N * MAT_N;
    localparam int unsigned OPERAND_WORDS = 2 * MAT_ELEMS;

    localparam int unsigned WORD_CNT_W   = 5;
    localparam int unsigned OUT_IDX_W    = 4;
    localparam int unsigned SETTLE_CNT_W = 4;

    // Bit offset of a matrix slot in a flat bus; slot 0 sits in the low word.
    function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned w);
        return slot * w;
    endfunction

endpackage

// File: rtl/matmul_word_bank.sv
// Nine-entry register bank with a flat MAT_ELEMS*W output.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset (clears all slots)
//   i_we, i_idx   - single-slot write enable and slot index (0..8)
//   i_wdata       - word written to slot i_idx
//   i_load_all    - parallel load of every slot from i_load_data (wins over i_we)
//   i_load_data   - flat parallel-load source
//   o_mat         - flat contents, slot 0 in bits [W-1:0]
module matmul_word_bank
    import matmul_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [OUT_IDX_W-1:0]     i_idx,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_load_all,
    input  logic [MAT_ELEMS*W-1:0]   i_load_data,
    output logic [MAT_ELEMS*W-1:0]   o_mat
);

    logic [MAT_ELEMS*W-1:0] r_mat;

    // Storage; out-of-range indices are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mat <= '0;
        end else if (i_load_all) begin
            r_mat <= i_load_data;
        end else if (i_we && (i_idx < OUT_IDX_W'(MAT_ELEMS))) begin
            r_mat[slot_lsb(32'(i_idx), W) +: W] <= i_wdata;
        end
    end

    assign o_mat = r_mat;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Word-serial sequencer for the 3x3 combinational matrix-multiply datapath.
// Loads A then B (18 row-major words), holds them stable on a_mat/b_mat,
// waits SETTLE_CYCLES, captures c_mat and streams 9 result words out.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid/in_data/in_ready    - operand word stream (A00..A22, B00..B22)
//   out_valid/out_data/out_ready - result word stream (C00..C22)
//   out_last                - marks C22
//   abort                   - synchronous job abort, keeps operand/result regs
//   a_mat, b_mat            - operand registers to the datapath
//   c_mat                   - datapath result
//   busy                    - job in progress
//   done                    - one-cycle pulse after the C22 transfer
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned W             = 32,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    input  logic                   out_ready,
    output logic                   out_last,
    input  logic                   abort,
    output logic [MAT_ELEMS*W-1:0] a_mat,
    output logic [MAT_ELEMS*W-1:0] b_mat,
    input  logic [MAT_ELEMS*W-1:0] c_mat,
    output logic                   busy,
    output logic                   done
);

    state_t                  r_state,      w_state_nxt;
    logic [WORD_CNT_W-1:0]   r_word_cnt,   w_word_cnt_nxt;
    logic [SETTLE_CNT_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
    logic [OUT_IDX_W-1:0]    r_out_idx,    w_out_idx_nxt;
    logic                    r_out_valid,  w_out_valid_nxt;
    logic                    r_out_last,   w_out_last_nxt;
    logic                    r_busy,       w_busy_nxt;
    logic                    r_done,       w_done_nxt;

    logic                    w_in_ready;
    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_wr;
    logic                    w_a_we;
    logic                    w_b_we;
    logic                    w_capture;
    logic [MAT_ELEMS*W-1:0]  w_res_mat;

    assign w_in_ready = rst_n && (r_state == S_LOAD);
    assign w_in_hs    = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    // Abort discards a word offered in the same cycle.
    assign w_wr      = w_in_hs && !abort;
    assign w_a_we    = w_wr && (r_word_cnt <  WORD_CNT_W'(MAT_ELEMS));
    assign w_b_we    = w_wr && (r_word_cnt >= WORD_CNT_W'(MAT_ELEMS));
    assign w_capture = (r_state == S_SETTLE) && !abort &&
                       (r_settle_cnt == SETTLE_CNT_W'(SETTLE_CYCLES - 1));

    matmul_word_bank #(.W(W)) u_a_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_a_we),
        .i_idx       (OUT_IDX_W'(r_word_cnt)),
        .i_wdata     (in_data),
        .i_load_all  (1'b0),
        .i_load_data ('0),
        .o_mat       (a_mat)
    );

    matmul_word_bank #(.W(W)) u_b_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_b_we),
        .i_idx       (OUT_IDX_W'(r_word_cnt - WORD_CNT_W'(MAT_ELEMS))),
        .i_wdata     (in_data),
        .i_load_all  (1'b0),
        .i_load_data ('0),
        .o_mat       (b_mat)
    );

    matmul_word_bank #(.W(W)) u_res_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (1'b0),
        .i_idx       ('0),
        .i_wdata     ('0),
        .i_load_all  (w_capture),
        .i_load_data (c_mat),
        .o_mat       (w_res_mat)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_word_cnt   <= '0;
            r_settle_cnt <= '0;
            r_out_idx    <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_out_idx    <= w_out_idx_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_last   <= w_out_last_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next-state, counters, and registered-output precompute.
    always_comb begin
        w_state_nxt      = r_state;
        w_word_cnt_nxt   = r_word_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_out_idx_nxt    = r_out_idx;
        w_done_nxt       = 1'b0;

        case (r_state)
            S_LOAD: begin
                if (w_in_hs) begin
                    w_word_cnt_nxt = r_word_cnt + WORD_CNT_W'(1);
                    if (r_word_cnt == WORD_CNT_W'(OPERAND_WORDS - 1)) begin
                        w_state_nxt      = S_SETTLE;
                        w_settle_cnt_nxt = '0;
                    end
                end
            end
            S_SETTLE: begin
                w_settle_cnt_nxt = r_settle_cnt + SETTLE_CNT_W'(1);
                if (r_settle_cnt == SETTLE_CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt   = S_DRAIN;
                    w_out_idx_nxt = '0;
                end
            end
            S_DRAIN: begin
                if (w_out_hs) begin
                    if (r_out_idx == OUT_IDX_W'(MAT_ELEMS - 1)) begin
                        w_state_nxt    = S_LOAD;
                        w_word_cnt_nxt = '0;
                        w_out_idx_nxt  = '0;
                        w_done_nxt     = 1'b1;
                    end else begin
                        w_out_idx_nxt = r_out_idx + OUT_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase

        // Abort returns to idle without a done pulse; data registers are kept.
        if (abort) begin
            w_state_nxt      = S_LOAD;
            w_word_cnt_nxt   = '0;
            w_settle_cnt_nxt = '0;
            w_out_idx_nxt    = '0;
            w_done_nxt       = 1'b0;
        end

        w_out_valid_nxt = (w_state_nxt == S_DRAIN);
        w_out_last_nxt  = (w_state_nxt == S_DRAIN) &&
                          (w_out_idx_nxt == OUT_IDX_W'(MAT_ELEMS - 1));
        w_busy_nxt      = (w_state_nxt != S_LOAD) || (w_word_cnt_nxt != '0);
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = w_res_mat[slot_lsb(32'(r_out_idx), W) +: W];
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
